// File: rtl/out_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong output buffer.
package out_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_st_t;

    function automatic int unsigned depth(input int unsigned nbadd);
        return 32'd1 << nbadd;
    endfunction

    function automatic int unsigned word_w(input int unsigned nbits);
        return 32'd2 * nbits;
    endfunction

endpackage

// File: rtl/obuf_dpram.sv
// Simple dual-port RAM, synchronous write and registered read with read enable.
module obuf_dpram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/out_pingpong_buf.sv
// Two-bank frame buffer: producer fills bank wb while the consumer streams bank rb.
module out_pingpong_buf
    import out_buf_pkg::*;
#(
    parameter int unsigned NBADD = 12,
    parameter int unsigned NBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [2*NBITS-1:0] wr_data,
    input  logic               wr_last,
    output logic               wr_full,
    output logic               ovf_err,
    input  logic               err_clr,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [2*NBITS-1:0] rd_data,
    output logic               rd_last,
    output logic [NBADD:0]     rd_len
);

    localparam int unsigned DEPTH  = depth(NBADD);
    localparam int unsigned WORD_W = word_w(NBITS);
    localparam int unsigned LEN_W  = NBADD + 1;
    localparam int unsigned RAM_AW = NBADD + 1;

    bank_st_t          bank_st     [2];
    bank_st_t          bank_st_nxt [2];
    logic [LEN_W-1:0]  len_q       [2];
    logic [LEN_W-1:0]  len_nxt     [2];
    logic              wb, wb_nxt, rb, rb_nxt;
    logic [NBADD-1:0]  waddr, waddr_nxt, raddr, raddr_nxt;
    rd_st_t            state, state_nxt;
    logic              ready_q, ready_nxt;
    logic              ovf_nxt, wr_full_nxt, rd_valid_nxt, rd_last_nxt;
    logic [LEN_W-1:0]  rd_len_nxt;
    logic              wr_acc, wr_drop, wr_commit, rd_is_last;
    logic              ram_re;
    logic [RAM_AW-1:0] ram_raddr;
    logic [WORD_W-1:0] ram_q;

    obuf_dpram #(
        .AW(RAM_AW),
        .DW(WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr ({wb, waddr}),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Next-state for banks, pointers, read FSM and registered outputs.
    always_comb begin
        bank_st_nxt = bank_st;
        len_nxt     = len_q;
        wb_nxt      = wb;
        rb_nxt      = rb;
        waddr_nxt   = waddr;
        raddr_nxt   = raddr;
        state_nxt   = state;
        ovf_nxt     = ovf_err;
        ram_re      = 1'b0;
        ram_raddr   = {rb, raddr};

        wr_acc     = wr_en && (bank_st[wb] != FULL);
        wr_drop    = wr_en && (bank_st[wb] == FULL);
        wr_commit  = wr_acc && (wr_last || (waddr == NBADD'(DEPTH - 1)));
        rd_is_last = ({1'b0, raddr} == (len_q[rb] - LEN_W'(1)));

        if (wr_acc) begin
            bank_st_nxt[wb] = FILLING;
            waddr_nxt       = waddr + NBADD'(1);
            if (wr_commit) begin
                bank_st_nxt[wb] = FULL;
                len_nxt[wb]     = LEN_W'(waddr) + LEN_W'(1);
                wb_nxt          = ~wb;
                waddr_nxt       = '0;
            end
        end

        if (wr_drop) begin
            ovf_nxt = 1'b1;
        end else if (err_clr) begin
            ovf_nxt = 1'b0;
        end

        // A frame is seen ready for one full IDLE cycle before its first read is issued.
        ready_nxt = (state == IDLE) && (bank_st[rb] == FULL);

        case (state)
            IDLE: begin
                if (ready_q && (bank_st[rb] == FULL)) begin
                    ram_re    = 1'b1;
                    ram_raddr = {rb, NBADD'(0)};
                    raddr_nxt = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (rd_ready) begin
                    if (rd_is_last) begin
                        bank_st_nxt[rb] = EMPTY;
                        rb_nxt          = ~rb;
                        state_nxt       = IDLE;
                    end else begin
                        raddr_nxt = raddr + NBADD'(1);
                        ram_re    = 1'b1;
                        ram_raddr = {rb, raddr + NBADD'(1)};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        wr_full_nxt  = (bank_st_nxt[wb_nxt] == FULL);
        rd_valid_nxt = (state_nxt == STREAM);
        rd_last_nxt  = (state_nxt == STREAM) &&
                       ({1'b0, raddr_nxt} == (len_nxt[rb_nxt] - LEN_W'(1)));
        rd_len_nxt   = (state_nxt == STREAM) ? len_nxt[rb_nxt] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            waddr      <= '0;
            raddr      <= '0;
            state      <= IDLE;
            ready_q    <= 1'b0;
            ovf_err    <= 1'b0;
            wr_full    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_len     <= '0;
        end else begin
            bank_st  <= bank_st_nxt;
            len_q    <= len_nxt;
            wb       <= wb_nxt;
            rb       <= rb_nxt;
            waddr    <= waddr_nxt;
            raddr    <= raddr_nxt;
            state    <= state_nxt;
            ready_q  <= ready_nxt;
            ovf_err  <= ovf_nxt;
            wr_full  <= wr_full_nxt;
            rd_valid <= rd_valid_nxt;
            rd_last  <= rd_last_nxt;
            rd_len   <= rd_len_nxt;
        end
    end

    // RAM output is not reset, so hide it whenever nothing is being presented.
    assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: doc/out_pingpong_buf.md
# out_pingpong_buf

Double-buffered (ping-pong) sample buffer for the VPPM receiver output path. A producer writes frames of signed I/Q words sequentially into one bank while a consumer drains the other bank through a valid/ready stream. Banks swap on frame commit, so demodulator output can be captured at full rate while the previous frame is read out. Successor to the single-bank addressed output buffer, with frame-length tracking, overflow flagging and back-pressure.

## Interface
- NBADD, 12, address bits per bank; bank depth 2**NBADD words
- NBITS, 16, component width; one word = 2*NBITS (I and Q packed)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one word this cycle
- wr_data  in  2*NBITS  signed word to store
- wr_last  in  1  with wr_en: this word ends the frame
- wr_full  out  1  no bank available for writing; writes are dropped
- ovf_err  out  1  sticky: a write was dropped
- err_clr  in  1  clears ovf_err
- rd_valid  out  1  rd_data/rd_last/rd_len are valid
- rd_ready  in  1  consumer accepts the word
- rd_data  out  2*NBITS  signed word being presented
- rd_last  out  1  final word of the frame
- rd_len  out  NBADD+1  length in words of the frame being read

## Operation
- Two banks, each in state EMPTY, FILLING or FULL, plus a per-bank length register (NBADD+1 bits). Write-bank pointer wb, read-bank pointer rb, both 0 after reset.
- Write side: on wr_en & !wr_full, store word at bank wb, address waddr, and mark the bank FILLING. Commit when wr_last=1 or waddr=2**NBADD-1 (forced commit). On commit: bank becomes FULL, length = waddr+1, wb toggles, waddr resets to 0.
- wr_full = 1 when bank wb is FULL. A wr_en while wr_full is dropped and sets ovf_err. ovf_err clears on err_clr; if a drop and err_clr occur in the same cycle, the set wins.
- Read FSM states:
  - IDLE: when bank rb is FULL, issue a read of address 0 and go to STREAM.
  - STREAM: rd_valid=1 and rd_data = RAM output register. On rd_valid & rd_ready:
    - not last: issue a read of the next address.
    - last (raddr = length-1): bank rb becomes EMPTY, rb toggles, go to IDLE.
- rd_last = STREAM & (raddr = length-1). rd_len = length of bank rb while in STREAM, otherwise 0.
- Commit (write side) and free (read side) in the same cycle act on different banks and are both honoured.
- Reset: banks EMPTY, pointers and counters 0, FSM IDLE, every output 0. RAM contents are not cleared. Asserting reset mid-frame discards all frames.

## Timing
- RAM is synchronous write, synchronous read with a read enable. The output register holds its value while read enable is low.
- Frame-ready latency: rd_valid rises 2 cycles after the edge that writes the committing word.
- Throughput: one word per cycle while rd_ready=1.
- rd_data, rd_last and rd_len remain stable while rd_valid=1 and rd_ready=0.
- Between frames, rd_valid is low for at least 2 cycles (one IDLE cycle plus the read latency).
- wr_full deasserts the cycle after the last word of bank wb is handshaken.

## Structure
- Package out_buf_pkg holds:
  - bank state enum (EMPTY/FILLING/FULL)
  - read FSM enum (IDLE/STREAM)
  - localparams DEPTH = 2**NBADD and WORD_W = 2*NBITS, as parameter-dependent functions
- One sub-module, obuf_dpram: simple dual-port RAM of 2*DEPTH words, addressed {bank, addr}, with registered read and a read enable. It must infer block RAM.
- Write control and read FSM stay in the top module.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0, wr_full=0, rd_valid=0 the following cycle; the next frame is read correctly.
- Single frame: write 1,2,3,4 (wr_last on 4), rd_ready=1 -> rd_valid rises 2 cycles after the write of 4; data 1,2,3,4 on consecutive cycles; rd_last with 4; rd_len=4.
- Back-pressure: same frame with rd_ready toggling 1010… -> each word held until accepted; no duplicates or losses.
- Overflow: rd_ready=0, commit frames A (2 words) and B (3 words), then write 0x55 -> wr_full=1, word dropped, ovf_err=1. Drain A -> wr_full=0; B then reads intact with rd_len=3. err_clr -> ovf_err=0.
- Forced commit (NBADD=3): write 8 words with no wr_last -> bank commits; rd_len=8; rd_last on the 8th word; the 9th write goes to the other bank.
- Simultaneous commit/free: commit the second frame in the same cycle the first frame's last word is handshaken -> both banks tracked correctly; second frame reads out intact.
